mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle for the multiply/divide unit.
// master drives requests and mt writes; slave returns status and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] mtData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, mthi, mtlo, mtData,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, A, B, mthi, mtlo, mtData,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// One shift-add or restoring shift-subtract step per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             div0;
    logic             done_q;

    logic             accept;
    logic             last;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             sub_ok;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    assign accept = (state == IDLE) && bus.start;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Operand magnitudes and sign flags captured on accept
    always_comb begin
        is_signed = ~bus.op[0];
        a_neg     = is_signed & bus.A[WIDTH-1];
        b_neg     = is_signed & bus.B[WIDTH-1];
        a_mag     = a_neg ? -bus.A : bus.A;
        b_mag     = b_neg ? -bus.B : bus.B;
    end

    // One iteration: multiplier add, divider trial subtract
    always_comb begin
        add_sum   = {1'b0, acc} + (qr[0] ? {1'b0, opd} : '0);
        rem_shift = {acc, qr[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opd};
        sub_ok    = (rem_shift >= {1'b0, opd});
    end

    // Sign correction and result selection for the finish edge
    always_comb begin
        prod     = {acc, qr};
        prod_fix = neg_lo ? -prod : prod;
        quo_fix  = neg_lo ? -qr : qr;
        rem_fix  = neg_hi ? -acc : acc;
        fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = prod_fix[WIDTH-1:0];
        // A zero divisor leaves |A| in the remainder, so only LO is forced
        unique case (1'b1)
            (is_div && div0): begin
                fin_hi = rem_fix;
                fin_lo = '1;
            end
            (is_div && !div0): begin
                fin_hi = rem_fix;
                fin_lo = quo_fix;
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, iteration counter, HI/LO and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            qr     <= '0;
            opd    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= '0;
                        is_div <= bus.op[1];
                        div0   <= bus.op[1] && (bus.B == '0);
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        if (bus.op[1]) begin
                            qr  <= a_mag;
                            opd <= b_mag;
                        end else begin
                            qr  <= b_mag;
                            opd <= a_mag;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.mtData;
                        if (bus.mtlo) lo_q <= bus.mtData;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        if (sub_ok) begin
                            acc <= rem_diff[WIDTH-1:0];
                            qr  <= {qr[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= rem_shift[WIDTH-1:0];
                            qr  <= {qr[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc, qr} <= {add_sum, qr[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    hi_q   <= fin_hi;
                    lo_q   <= fin_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued ops push expected HI/LO,
// a monitor pops and compares on each done pulse.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    res_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic from the ISA rules
    function automatic res_t model(logic [1:0] op, logic [W-1:0] a,
                                   logic [W-1:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        res_t res;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        if (!op[1]) begin
            p = sa * sb;
            res.hi = p[63:32];
            res.lo = p[31:0];
        end else if (b == 0) begin
            res.hi = a;
            res.lo = '1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            res.hi = r[31:0];
            res.lo = q[31:0];
        end
        return res;
    endfunction

    // Monitor: compare every done pulse against the scoreboard head
    always @(negedge clk) begin
        res_t e;
        if (!reset && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got HI=%h LO=%h expected none",
                         bus.HI, bus.LO);
            end else begin
                e = exp_q.pop_front();
                check("result_hi", bus.HI, e.hi);
                check("result_lo", bus.LO, e.lo);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %b expected 0", bus.busy);
        end
    endtask

    task automatic issue(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b,
                         bit mid_start, bit mt_with_start);
        int n;
        int d0;
        res_t r;
        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        if (mt_with_start) begin
            bus.mthi   = 1'b1;
            bus.mtlo   = 1'b1;
            bus.mtData = 32'h5555AAAA;
        end
        r = model(op, a, b);
        exp_q.push_back(r);
        d0 = done_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        if (mt_with_start) begin
            check("mt_dropped_hi", bus.HI, model_hi);
            check("mt_dropped_lo", bus.LO, model_lo);
        end
        n = 0;
        while (bus.busy && n < 100) begin
            if (mid_start && n == 5) begin
                bus.start  = 1'b1;
                bus.op     = 2'($urandom);
                bus.A      = $urandom;
                bus.B      = $urandom;
                bus.mthi   = 1'b1;
                bus.mtData = 32'hDEADBEEF;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check("busy_cycles", W'(n), W'(33));
        #1;
        check("done_pulses", W'(done_cnt - d0), W'(1));
        model_hi = r.hi;
        model_lo = r.lo;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] edges [5];
        edges[0] = 32'h0;
        edges[1] = 32'h1;
        edges[2] = 32'hFFFFFFFF;
        edges[3] = 32'h80000000;
        edges[4] = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return W'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.A      = '0;
        bus.B      = '0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.mtData = '0;
        model_hi   = '0;
        model_lo   = '0;
        reset      = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_hi", bus.HI, '0);
        check("reset_lo", bus.LO, '0);
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);

        issue(2'b01, 32'd7, 32'd6, 0, 0);
        issue(2'b00, 32'hFFFFFFFD, 32'd5, 0, 0);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        issue(2'b11, 32'd100, 32'd7, 0, 0);
        issue(2'b11, 32'h12345678, 32'd0, 0, 0);
        issue(2'b10, 32'hFFFFFF00, 32'd0, 0, 0);
        issue(2'b01, 32'd3, 32'd4, 1, 0);

        wait_idle();
        @(negedge clk);
        bus.mtlo   = 1'b1;
        bus.mtData = 32'hCAFEF00D;
        @(negedge clk);
        bus.mtlo = 1'b0;
        check("mtlo_lo", bus.LO, 32'hCAFEF00D);
        check("mtlo_hi", bus.HI, model_hi);
        model_lo = 32'hCAFEF00D;
        bus.mthi   = 1'b1;
        bus.mtlo   = 1'b1;
        bus.mtData = 32'h0BADF00D;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mtboth_hi", bus.HI, 32'h0BADF00D);
        check("mtboth_lo", bus.LO, 32'h0BADF00D);
        model_hi = 32'h0BADF00D;
        model_lo = 32'h0BADF00D;

        issue(2'b00, 32'd9, 32'hFFFFFFFE, 0, 1);

        wait_idle();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        exp_q.push_back(model(2'b11, 32'd100, 32'd7));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", W'(bus.busy), '0);
        check("midrst_done", W'(bus.done), '0);
        check("midrst_hi", bus.HI, '0);
        check("midrst_lo", bus.LO, '0);
        model_hi = '0;
        model_lo = '0;
        repeat (40) @(negedge clk);
        issue(2'b01, 32'd2, 32'd3, 0, 0);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), pick(), pick(), ($urandom_range(0, 4) == 0), 0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_empty", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
